// File: rtl/ram_arbiter.sv
// Two-port load/store arbiter and sequencer in front of a four-lane byte-enable data RAM.
// Define RAM_ARB_RR_EN for round-robin tie breaking; otherwise port 0 has fixed priority.
module ram_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [1:0]  m0_size,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [1:0]  m1_size,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,
    output logic [3:0]  ram_wen,
    output logic [31:0] ram_w_addr,
    output logic [31:0] ram_r_addr,
    output logic [31:0] ram_w_data,
    output logic        ram_ren,
    input  logic [31:0] ram_r_data
);

    typedef enum logic [1:0] {IDLE, WR, RD, RESP} state_t;

    state_t      state;
    logic        last_grant;
    logic        grant_q;
    logic        we_q;
    logic        err_q;
    logic [1:0]  size_q;
    logic [1:0]  offset_q;

    logic        sel;
    logic        sel_we;
    logic [1:0]  sel_size;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [31:0] resp_data;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'd0:    return 1'b0;
            2'd1:    return a[0];
            default: return a != 2'd0;
        endcase
    endfunction

    function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'd0:    return 4'b0001 << a;
            2'd1:    return 4'b0011 << {a[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'd0:    return {4{d[7:0]}};
            2'd1:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] align_read(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] a);
        logic [31:0] shifted;
        shifted = word >> {a, 3'b000};
        case (size)
            2'd0:    return {24'd0, shifted[7:0]};
            2'd1:    return {16'd0, shifted[15:0]};
            default: return shifted;
        endcase
    endfunction

    // Winner selection; with nobody requesting sel is ignored and simply parks on last_grant.
    always_comb begin
        sel = last_grant;
`ifdef RAM_ARB_RR_EN
        if (m0_req && m1_req)
            sel = ~last_grant;
        else if (m0_req || m1_req)
            sel = m1_req;
`else
        if (m0_req)
            sel = 1'b0;
        else if (m1_req)
            sel = 1'b1;
`endif
    end

    assign sel_we    = sel ? m1_we    : m0_we;
    assign sel_size  = sel ? m1_size  : m0_size;
    assign sel_addr  = sel ? m1_addr  : m0_addr;
    assign sel_wdata = sel ? m1_wdata : m0_wdata;

    // RAM read data only becomes valid in RESP, so load data is steered combinationally there.
    assign resp_data = (state == RESP && !err_q && !we_q)
                       ? align_read(ram_r_data, size_q, offset_q) : 32'd0;
    assign m0_rdata  = grant_q ? 32'd0 : resp_data;
    assign m1_rdata  = grant_q ? resp_data : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant_q    <= 1'b0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            size_q     <= 2'd0;
            offset_q   <= 2'd0;
            m0_ack     <= 1'b0;
            m0_err     <= 1'b0;
            m1_ack     <= 1'b0;
            m1_err     <= 1'b0;
            ram_wen    <= 4'd0;
            ram_ren    <= 1'b0;
            ram_w_addr <= 32'd0;
            ram_r_addr <= 32'd0;
            ram_w_data <= 32'd0;
        end else begin
            m0_ack     <= 1'b0;
            m0_err     <= 1'b0;
            m1_ack     <= 1'b0;
            m1_err     <= 1'b0;
            ram_wen    <= 4'd0;
            ram_ren    <= 1'b0;
            ram_w_addr <= 32'd0;
            ram_r_addr <= 32'd0;
            ram_w_data <= 32'd0;
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        last_grant <= sel;
                        grant_q    <= sel;
                        we_q       <= sel_we;
                        size_q     <= sel_size;
                        offset_q   <= sel_addr[1:0];
                        err_q      <= is_misaligned(sel_size, sel_addr[1:0]);
                        if (is_misaligned(sel_size, sel_addr[1:0])) begin
                            state  <= RESP;
                            m0_ack <= ~sel;
                            m0_err <= ~sel;
                            m1_ack <= sel;
                            m1_err <= sel;
                        end else if (sel_we) begin
                            state      <= WR;
                            ram_wen    <= lane_enables(sel_size, sel_addr[1:0]);
                            ram_w_addr <= {sel_addr[31:2], 2'b00};
                            ram_w_data <= lane_data(sel_size, sel_wdata);
                            m0_ack     <= ~sel;
                            m1_ack     <= sel;
                        end else begin
                            state      <= RD;
                            ram_ren    <= 1'b1;
                            ram_r_addr <= {sel_addr[31:2], 2'b00};
                        end
                    end
                end
                WR: state <= IDLE;
                RD: begin
                    state  <= RESP;
                    m0_ack <= ~grant_q;
                    m1_ack <= grant_q;
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter and sequencer in front of the 16 KiB byte-lane data RAM (four 8-bit banks, per-byte write enables, word index = address[13:2]). It accepts load/store requests from the core load/store unit (port 0) and the program-loader/debug port (port 1), serialises them onto the single RAM port, and generates byte-lane write enables, replicated write data and aligned read data. It also flags misaligned accesses.

## Interface
- No parameters; data width fixed at 32, size encoding fixed at 2 bits.
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- m0_req / m1_req  in  1  request valid; held with fields stable until the matching ack
- m0_we / m1_we  in  1  1 = store, 0 = load
- m0_size / m1_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word
- m0_addr / m1_addr  in  32  byte address
- m0_wdata / m1_wdata  in  32  store data, right-aligned (bits [7:0] for byte, [15:0] for half)
- m0_ack / m1_ack  out  1  one-cycle completion pulse
- m0_err / m1_err  out  1  valid with ack; 1 = misaligned, no RAM access made
- m0_rdata / m1_rdata  out  32  load data, valid with ack, zero-extended to size
- ram_wen  out  4  byte write enables
- ram_w_addr / ram_r_addr  out  32  byte address to RAM, low two bits forced to 0
- ram_w_data  out  32  lane-replicated write data
- ram_ren  out  1  read enable
- ram_r_data  in  32  RAM read word, registered, valid the cycle after ram_ren

## Operation
- FSM states: IDLE, WR, RD, RESP. Reset puts the FSM in IDLE.
- IDLE: when any req is high, pick a winner and latch its we, size, addr and wdata into a request register. Record the winner in last_grant.
  - Aligned store goes to WR; aligned load goes to RD.
  - Misaligned access goes to RESP with err set.
- Misaligned means half with addr[0]=1, or word with addr[1:0]≠0.
- WR: drive ram_wen, ram_w_addr and ram_w_data from the request register. Pulse ack to the winner, then go to IDLE.
- RD: drive ram_ren=1 and ram_r_addr, then go to RESP.
- RESP: pulse ack (and err if set) to the winner, drive rdata, then go to IDLE.
- Write enables:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << {addr[1],1'b0}
  - word: 4'b1111
- Write data:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Read data: ram_r_data >> (8*addr[1:0]), masked to 8, 16 or 32 bits by size. Sign extension is the requester's job.
- rdata for a store or an err ack is 0. The non-granted port's ack, err and rdata stay 0.
- The address is passed through unchecked. Out-of-range addresses alias per the RAM's word-index decode.
- ram_wen and ram_ren are never high in the same cycle. At most one RAM access is in flight.
- Outputs in reset and in IDLE: all acks, errs, rdata, ram_wen and ram_ren are 0. ram addresses and ram_w_data are 0.

## Timing
- A request sampled in IDLE at cycle T has the following latency:
  - store: RAM write at the end of T+1; ack in T+1.
  - load: ram_ren in T+1, ack and rdata in T+2.
  - misaligned: ack+err in T+1.
- After an ack the FSM is in IDLE in the next cycle. A requester holding req for a new transaction is sampled then.
- Steady-state throughput is therefore one store per 2 cycles and one load per 3 cycles.
- A req that drops before its ack is a protocol violation; behaviour is unspecified.
- Once latched, the request register is immune to requester input changes.
- Simultaneous requests are resolved in IDLE only. There is no pre-emption.
- rst high in any state gives IDLE next cycle: an in-flight transaction is dropped, no ack is issued, last_grant is reset to port 1, and the RAM contents are untouched.

## Configuration
- RAM_ARB_RR_EN defined: round-robin. With both req high in IDLE, grant the port that is not last_grant. After reset port 0 wins the first tie.
- RAM_ARB_RR_EN undefined: fixed priority, port 0 always wins ties. last_grant is still tracked but does not affect the choice.

## Test plan
- Port 0 stores word 0xDEADBEEF at 0x100, then loads it back.
  - Store: ram_wen=4'b1111 in T+1.
  - Load: ack in T+2 with rdata=0xDEADBEEF.
- Port 0 does sb 0xA5 at 0x103, then lhu at 0x102.
  - Store: ram_wen=4'b1000, ram_w_data=0xA5A5A5A5.
  - Load: rdata=0x0000A5EF, given byte 0x102 previously held 0xEF.
- Port 1 does sw at 0x202 and lh at 0x101.
  - Each gets ack+err in T+1.
  - ram_wen and ram_ren stay 0 throughout.
- Both ports hold load requests continuously for 4 grants.
  - With RAM_ARB_RR_EN, grants go 0,1,0,1.
  - Without it, grants go 0,0,0,0 and port 1 is starved.
- rst is asserted in RD.
  - No ack and no ram_ren in the following cycle; FSM in IDLE.
  - A subsequent load returns correct data.
- Port 1 does sw 0x11223344 at 0x3FFC, then lbu at 0x3FFF.
  - Load returns rdata=0x00000011 (top word, lane 3).
